// File: rtl/alu_if.sv
// Operand/result bundle between the ALU-control side of the datapath and the ALU.
// master drives operands and op; slave (the ALU) returns the registered result and zero flag.
interface alu_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       op;
    logic [WIDTH-1:0] resultado;
    logic             zero_flag;

    modport master (
        output A, B, op,
        input  resultado, zero_flag
    );

    modport slave (
        input  A, B, op,
        output resultado, zero_flag
    );
endinterface

// File: rtl/alu.sv
// Registered 32-bit MIPS ALU (AND/OR/ADD/SUB/SLT/NOR, optional DIV), one-cycle latency.
// Define ALU_DIV_EN to build the signed divider for op 1010; otherwise 1010 yields 0.
module alu #(
    parameter int WIDTH = 32
) (
    input logic  clk,
    input logic  rst_n,
    alu_if.slave bus
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_DIV = 4'b1010;

    logic [WIDTH-1:0] result_next;
    logic             slt_bit;

    assign slt_bit = ($signed(bus.A) < $signed(bus.B));

`ifdef ALU_DIV_EN
    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] div_result;

    // Divide-by-zero and INT_MIN / -1 are pinned explicitly rather than left to the operator.
    always_comb begin
        if (bus.B == '0) begin
            div_result = '1;
        end else if (bus.A == INT_MIN && bus.B == '1) begin
            div_result = INT_MIN;
        end else begin
            div_result = $signed(bus.A) / $signed(bus.B);
        end
    end
`endif

    always_comb begin
        // NOTE: default assignment first so every path drives result_next and no latch is inferred.
        result_next = '0;
        case (bus.op)
            OP_AND:  result_next = bus.A & bus.B;
            OP_OR:   result_next = bus.A | bus.B;
            OP_ADD:  result_next = bus.A + bus.B;
            OP_SUB:  result_next = bus.A - bus.B;
            OP_SLT:  result_next = {{(WIDTH-1){1'b0}}, slt_bit};
            OP_NOR:  result_next = ~(bus.A | bus.B);
`ifdef ALU_DIV_EN
            OP_DIV:  result_next = div_result;
`endif
            default: result_next = '0;
        endcase
    end

    // Flag comes from the same value being registered, so both outputs move together.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            bus.resultado <= '0;
            bus.zero_flag <= 1'b1;
        end else begin
            bus.resultado <= result_next;
            bus.zero_flag <= (result_next == '0);
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases followed by random ops against a reference model.
// Directed DIV expectations follow whether ALU_DIV_EN is defined for the build.
module tb_alu;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_if #(.WIDTH(32)) bus ();

    alu #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain arithmetic on 64-bit signed values, truncated back to 32 bits.
    function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return 32'(sa + sb);
            4'b0110: return 32'(sa - sb);
            4'b0111: return (sa < sb) ? 32'd1 : 32'd0;
            4'b1100: return ~(a | b);
`ifdef ALU_DIV_EN
            4'b1010: return (sb == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic compare(input string tag, input logic [31:0] exp_res);
        logic exp_zero;
        exp_zero = (exp_res == 32'd0);
        checks++;
        assert (bus.resultado === exp_res) else begin
            errors++;
            $error("FAIL %s resultado: got %h expected %h", tag, bus.resultado, exp_res);
        end
        checks++;
        assert (bus.zero_flag === exp_zero) else begin
            errors++;
            $error("FAIL %s zero_flag: got %b expected %b", tag, bus.zero_flag, exp_zero);
        end
    endtask

    // Apply inputs, let one rising edge pass, then sample 1 time unit after that edge.
    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [3:0] o,
                        input logic [31:0] exp_res, input string tag);
        bus.A  = a;
        bus.B  = b;
        bus.op = o;
        @(posedge clk);
        #1;
        compare(tag, exp_res);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [3:0]  ro;
        logic [3:0]  op_pool [8];
        logic [31:0] div_100_20;
        logic [31:0] div_100_0;
        logic [31:0] div_m7_2;
        logic [31:0] div_min_m1;

        checks = 0;
        errors = 0;
        op_pool = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1010, 4'b1111};

`ifdef ALU_DIV_EN
        div_100_20 = 32'd5;
        div_100_0  = 32'hFFFF_FFFF;
        div_m7_2   = 32'hFFFF_FFFD;
        div_min_m1 = 32'h8000_0000;
`else
        div_100_20 = 32'd0;
        div_100_0  = 32'd0;
        div_m7_2   = 32'd0;
        div_min_m1 = 32'd0;
`endif

        rst_n = 1'b0;
        @(negedge clk);
        step(32'd15, 32'd20, 4'b0010, 32'd0, "reset_cycle1");
        step(32'd15, 32'd20, 4'b0010, 32'd0, "reset_cycle2");
        rst_n = 1'b1;
        step(32'd15, 32'd20, 4'b0010, 32'd35, "reset_release_add");

        step(32'b1010, 32'b1100, 4'b0000, 32'd8,  "and");
        step(32'b1010, 32'b1100, 4'b0001, 32'd14, "or");
        step(32'd15,   32'd20,   4'b0010, 32'd35, "add");
        step(32'd30,   32'd12,   4'b0110, 32'd18, "sub");
        step(32'd12,   32'd12,   4'b0110, 32'd0,  "sub_zero");
        step(32'hFFFF_FFFF, 32'd1, 4'b0010, 32'd0, "add_wrap");
        step(32'd0,    32'd1,    4'b0110, 32'hFFFF_FFFF, "sub_wrap");
        step(32'd5,    32'd10,   4'b0111, 32'd1,  "slt_lt");
        step(32'd10,   32'd5,    4'b0111, 32'd0,  "slt_gt");
        step(32'hFFFF_FFFF, 32'd1, 4'b0111, 32'd1, "slt_signed");
        step(32'd1, 32'h8000_0000, 4'b0111, 32'd0, "slt_vs_min");
        step(32'd100,  32'd20,   4'b1010, div_100_20, "div");
        step(32'd100,  32'd0,    4'b1010, div_100_0,  "div_by_zero");
        step(32'hFFFF_FFF9, 32'd2, 4'b1010, div_m7_2, "div_neg_trunc");
        step(32'h8000_0000, 32'hFFFF_FFFF, 4'b1010, div_min_m1, "div_min_by_m1");
        step(32'd0,    32'd0,    4'b1100, 32'hFFFF_FFFF, "nor");
        step(32'hDEAD_BEEF, 32'h1234_5678, 4'b1111, 32'd0, "undef_op");

        // Outputs must hold across the falling edge with no new rising edge.
        bus.op = 4'b1100;
        @(negedge clk);
        compare("hold", 32'd0);

        // Back-to-back random ops, a new op every cycle.
        for (int i = 0; i < 300; i++) begin
            ro = op_pool[$urandom_range(0, 7)];
            case ($urandom_range(0, 3))
                0: begin ra = $urandom_range(0, 64); rb = $urandom_range(0, 64); end
                1: begin ra = $urandom; rb = 32'd0; end
                2: begin ra = $urandom; rb = $urandom_range(0, 1) ? 32'hFFFF_FFFF : ra; end
                default: begin ra = $urandom; rb = $urandom; end
            endcase
            step(ra, rb, ro, model(ro, ra, rb), "random");
        end

        rst_n = 1'b0;
        step(32'd0, 32'd0, 4'b1100, 32'd0, "reset_priority");
        rst_n = 1'b1;
        step(32'd7, 32'd0, 4'b1100, 32'hFFFF_FFF8, "after_reset_nor");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
